// File: rtl/hazard_ctrl.sv
// Stall, forwarding and multiply/divide busy control for a 5-stage MIPS-subset pipeline.
// Optional macro HAZARD_CTRL_MD_EN enables the multiply/divide busy tracker and its interlock.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] IR_M,
  input  logic [31:0] IR_W,
  output logic        stall,
  output logic        clr_E,
  output logic [1:0]  fwd_rs_D,
  output logic [1:0]  fwd_rt_D,
  output logic [1:0]  fwd_rs_E,
  output logic [1:0]  fwd_rt_E,
  output logic        fwd_rt_M,
  output logic        md_busy
);

  typedef struct packed {
    logic       use_rs;
    logic       use_rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [1:0] tnew;      // producer latency as seen from E
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;       // 0 means no destination
    logic       is_lw;
    logic       is_sw;
    logic       md_start;
    logic       is_div;
    logic       md_op;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d    = '0;
    d.rs = ir[25:21];
    d.rt = ir[20:16];
    case (ir[31:26])
      6'h00: begin
        case (ir[5:0])
          6'h21, 6'h23: begin                     // addu, subu
            d.use_rs = 1'b1; d.tuse_rs = 2'd1;
            d.use_rt = 1'b1; d.tuse_rt = 2'd1;
            d.dst = ir[15:11]; d.tnew = 2'd1;
          end
          6'h08: begin d.use_rs = 1'b1; d.tuse_rs = 2'd0; end // jr
          6'h18, 6'h19, 6'h1a, 6'h1b: begin       // mult, multu, div, divu
            d.use_rs = 1'b1; d.tuse_rs = 2'd1;
            d.use_rt = 1'b1; d.tuse_rt = 2'd1;
`ifdef HAZARD_CTRL_MD_EN
            d.md_op = 1'b1; d.md_start = 1'b1; d.is_div = ir[1];
`else
            d.dst = ir[15:11]; d.tnew = 2'd1;
`endif
          end
          6'h10, 6'h12: begin                     // mfhi, mflo
            d.dst = ir[15:11]; d.tnew = 2'd1;
`ifdef HAZARD_CTRL_MD_EN
            d.md_op = 1'b1;
`endif
          end
          6'h11, 6'h13: begin                     // mthi, mtlo
            d.use_rs = 1'b1; d.tuse_rs = 2'd1;
`ifdef HAZARD_CTRL_MD_EN
            d.md_op = 1'b1;
`else
            d.dst = ir[15:11]; d.tnew = 2'd1;
`endif
          end
          default: d = '0;
        endcase
      end
      6'h0d: begin d.use_rs = 1'b1; d.tuse_rs = 2'd1; d.dst = ir[20:16]; d.tnew = 2'd1; end // ori
      6'h0f: begin d.dst = ir[20:16]; d.tnew = 2'd1; end                                  // lui
      6'h23: begin                                                                         // lw
        d.use_rs = 1'b1; d.tuse_rs = 2'd1;
        d.dst = ir[20:16]; d.tnew = 2'd2; d.is_lw = 1'b1;
      end
      6'h2b: begin                                                                         // sw
        d.use_rs = 1'b1; d.tuse_rs = 2'd1;
        d.use_rt = 1'b1; d.tuse_rt = 2'd2; d.is_sw = 1'b1;
      end
      6'h04: begin d.use_rs = 1'b1; d.use_rt = 1'b1; end                                   // beq
      6'h02: d = '0;                                                                       // j
      6'h03: begin d.dst = 5'd31; d.tnew = 2'd0; end                                       // jal
      default: d = '0;
    endcase
    return d;
  endfunction

  // A D-stage read conflicts with a producer in E or M that cannot deliver in time.
  function automatic logic raw_hazard(input logic use_r, input logic [4:0] r,
                                      input logic [1:0] tuse, input dec_t e, input dec_t m);
    logic hit_e, hit_m;
    hit_e = (r == e.dst) && (tuse < e.tnew);
    hit_m = (r == m.dst) && (tuse < {1'b0, m.is_lw});
    return use_r && (r != 5'd0) && (hit_e || hit_m);
  endfunction

  function automatic logic [1:0] src_d(input logic use_r, input logic [4:0] r,
                                       input dec_t e, input dec_t m, input dec_t w);
    logic [1:0] s;
    s = 2'd0;
    if (use_r && r != 5'd0) begin
      if (r == e.dst && e.tnew == 2'd0)  s = 2'd1;
      else if (r == m.dst && !m.is_lw)   s = 2'd2;
      else if (r == w.dst)               s = 2'd3;
    end
    return s;
  endfunction

  function automatic logic [1:0] src_e(input logic use_r, input logic [4:0] r,
                                       input dec_t m, input dec_t w);
    logic [1:0] s;
    s = 2'd0;
    if (use_r && r != 5'd0) begin
      if (r == m.dst && !m.is_lw) s = 2'd2;
      else if (r == w.dst)        s = 2'd3;
    end
    return s;
  endfunction

  dec_t dec_d, dec_e, dec_m, dec_w;
  logic md_stall;

  assign dec_d = decode(IR_D);
  assign dec_e = decode(IR_E);
  assign dec_m = decode(IR_M);
  assign dec_w = decode(IR_W);

`ifdef HAZARD_CTRL_MD_EN
  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  md_state_t        md_state;
  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] md_load;
  logic             unused_bits;

  assign md_load = dec_e.is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

  // Busy tracker: a new start always reloads; the count saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
    end else if (dec_e.md_start) begin
      md_state <= (md_load != '0) ? MD_BUSY : MD_IDLE;
      md_cnt   <= md_load;
    end else if (md_state == MD_BUSY) begin
      if (md_cnt <= CNT_W'(1)) begin
        md_state <= MD_IDLE;
        md_cnt   <= '0;
      end else begin
        md_cnt <= md_cnt - CNT_W'(1);
      end
    end
  end

  assign md_busy     = (md_state == MD_BUSY) || dec_e.md_start;
  assign md_stall    = dec_d.md_op && md_busy;
  assign unused_bits = ^{dec_d, dec_e, dec_m, dec_w};
`else
  logic unused_bits;

  assign md_busy     = 1'b0;
  assign md_stall    = 1'b0;
  assign unused_bits = ^{clk, reset, dec_d, dec_e, dec_m, dec_w, (MULT_CYCLES == DIV_CYCLES)};
`endif

  assign stall = raw_hazard(dec_d.use_rs, dec_d.rs, dec_d.tuse_rs, dec_e, dec_m)
              || raw_hazard(dec_d.use_rt, dec_d.rt, dec_d.tuse_rt, dec_e, dec_m)
              || md_stall;
  assign clr_E = stall;

  assign fwd_rs_D = src_d(dec_d.use_rs, dec_d.rs, dec_e, dec_m, dec_w);
  assign fwd_rt_D = src_d(dec_d.use_rt, dec_d.rt, dec_e, dec_m, dec_w);
  assign fwd_rs_E = src_e(dec_e.use_rs, dec_e.rs, dec_m, dec_w);
  assign fwd_rt_E = src_e(dec_e.use_rt, dec_e.rt, dec_m, dec_w);
  assign fwd_rt_M = dec_m.is_sw && (dec_m.rt != 5'd0) && (dec_m.rt == dec_w.dst);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stage instruction words are driven per cycle with hand-computed expectations.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] IR_D, IR_E, IR_M, IR_W;
  logic        stall, clr_E, fwd_rt_M, md_busy;
  logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  int          errors;
  int          checks;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M), .IR_W(IR_W),
    .stall(stall), .clr_E(clr_E),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
    .fwd_rt_M(fwd_rt_M), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample two time units after driving, well clear of both clock edges.
  task automatic drive(input logic [31:0] d, input logic [31:0] e,
                       input logic [31:0] m, input logic [31:0] w);
    IR_D = d; IR_E = e; IR_M = m; IR_W = w;
    #2;
  endtask

  logic [31:0] lw8, addu9, beq8, sw8, addu5, beq5, jal, jr31;
  logic [31:0] beq00, addu0, ori0, lw0;
  logic [31:0] addu12a, addu12b, ori10, addu11, lui10, lw10, addu13, sw10, addu10;
  logic [31:0] mult12, lw1, mflo3, div12;

  initial begin
    errors = 0;
    checks = 0;
    lw8     = enc_i(6'h23, 29, 8, 0);
    addu9   = enc_r(8, 8, 9, 6'h21);
    beq8    = enc_i(6'h04, 8, 0, 0);
    sw8     = enc_i(6'h2b, 29, 8, 0);
    addu5   = enc_r(6, 7, 5, 6'h21);
    beq5    = enc_i(6'h04, 5, 0, 16);
    jal     = {6'h03, 26'h0000100};
    jr31    = enc_r(31, 0, 0, 6'h08);
    beq00   = enc_i(6'h04, 0, 0, 0);
    addu0   = enc_r(1, 2, 0, 6'h21);
    ori0    = enc_i(6'h0d, 1, 0, 5);
    lw0     = enc_i(6'h23, 1, 0, 0);
    addu12a = enc_r(10, 11, 12, 6'h21);
    addu12b = enc_r(10, 10, 12, 6'h21);
    ori10   = enc_i(6'h0d, 0, 10, 5);
    addu11  = enc_r(1, 2, 11, 6'h21);
    lui10   = enc_i(6'h0f, 0, 10, 1);
    lw10    = enc_i(6'h23, 29, 10, 0);
    addu13  = enc_r(10, 10, 13, 6'h21);
    sw10    = enc_i(6'h2b, 29, 10, 4);
    addu10  = enc_r(1, 2, 10, 6'h21);
    mult12  = enc_r(1, 2, 0, 6'h18);
    lw1     = enc_i(6'h23, 29, 1, 0);
    mflo3   = enc_r(0, 0, 3, 6'h12);
    div12   = enc_r(1, 2, 0, 6'h1a);

    reset = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    tick();
    chk("rst_stall", stall, 0);
    chk("rst_clr_E", clr_E, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_fwd_rs_D", fwd_rs_D, 0);
    chk("rst_fwd_rt_D", fwd_rt_D, 0);
    chk("rst_fwd_rs_E", fwd_rs_E, 0);
    chk("rst_fwd_rt_E", fwd_rt_E, 0);
    chk("rst_fwd_rt_M", fwd_rt_M, 0);
`ifdef HAZARD_CTRL_MD_EN
    chk("rst_md_cnt", int'(dut.md_cnt), 0);
`endif
    reset = 1'b0;
    tick();

    // load-use: one bubble, then W forwarding into E
    drive(addu9, lw8, 0, 0);
    chk("lwuse_stall", stall, 1);
    chk("lwuse_clr_E", clr_E, 1);
    tick();
    drive(addu9, 0, lw8, 0);
    chk("lwuse_stall_rel", stall, 0);
    chk("lwuse_clr_E_rel", clr_E, 0);
    tick();
    drive(0, addu9, 0, lw8);
    chk("lwuse_fwd_rs_E", fwd_rs_E, 3);
    chk("lwuse_fwd_rt_E", fwd_rt_E, 3);
    drive(beq8, 0, lw8, 0);
    chk("lw_m_beq_stall", stall, 1);
    drive(sw8, lw8, 0, 0);
    chk("sw_rt_lw_e_nostall", stall, 0);

    // branch compare on an ALU result
    drive(beq5, addu5, 0, 0);
    chk("beq_stall", stall, 1);
    tick();
    drive(beq5, 0, addu5, 0);
    chk("beq_stall_rel", stall, 0);
    chk("beq_fwd_rs_D", fwd_rs_D, 2);
    chk("beq_fwd_rt_D", fwd_rt_D, 0);

    // jal link register feeding jr
    drive(jr31, 0, jal, 0);
    chk("jr_m_stall", stall, 0);
    chk("jr_m_fwd_rs_D", fwd_rs_D, 2);
    drive(jr31, jal, 0, 0);
    chk("jr_e_stall", stall, 0);
    chk("jr_e_fwd_rs_D", fwd_rs_D, 1);
    drive(jr31, 0, 0, jal);
    chk("jr_w_fwd_rs_D", fwd_rs_D, 3);

    // $0 destinations never match
    drive(beq00, addu0, ori0, lw0);
    chk("zero_stall", stall, 0);
    chk("zero_fwd_rs_D", fwd_rs_D, 0);
    chk("zero_fwd_rt_D", fwd_rt_D, 0);
    chk("zero_fwd_rs_E", fwd_rs_E, 0);
    chk("zero_fwd_rt_E", fwd_rt_E, 0);

    // E-stage forwarding and priority
    drive(0, addu12a, ori10, addu11);
    chk("e_fwd_rs_M", fwd_rs_E, 2);
    chk("e_fwd_rt_W", fwd_rt_E, 3);
    drive(0, addu12b, ori10, lui10);
    chk("e_prio_rs", fwd_rs_E, 2);
    chk("e_prio_rt", fwd_rt_E, 2);
    drive(0, addu12b, lw10, lui10);
    chk("e_lw_m_skip_rs", fwd_rs_E, 3);
    chk("e_lw_m_skip_rt", fwd_rt_E, 3);

    // D-stage priority M over W
    drive(addu13, 0, ori10, lui10);
    chk("d_prio_stall", stall, 0);
    chk("d_prio_rs", fwd_rs_D, 2);
    chk("d_prio_rt", fwd_rt_D, 2);

    // store data in M from W
    drive(0, 0, sw10, addu10);
    chk("sw_fwd_rt_M", fwd_rt_M, 1);
    drive(0, 0, sw10, addu11);
    chk("sw_nofwd_rt_M", fwd_rt_M, 0);

    // md op reading a pending load
    drive(mult12, lw1, 0, 0);
    chk("mult_src_stall", stall, 1);
    drive(0, 0, 0, 0);
    tick();

`ifdef HAZARD_CTRL_MD_EN
    // mult: busy for 5 cycles starting when it enters E
    drive(mflo3, mult12, 0, 0);
    chk("mult_busy_0", md_busy, 1);
    chk("mult_stall_0", stall, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      drive(mflo3, 0, 0, 0);
      chk($sformatf("mult_busy_%0d", k), md_busy, (k < 5) ? 1 : 0);
      chk($sformatf("mult_stall_%0d", k), stall, (k < 5) ? 1 : 0);
    end
    tick();

    // div: busy for 10 cycles
    drive(mflo3, div12, 0, 0);
    chk("div_busy_0", md_busy, 1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      drive(mflo3, 0, 0, 0);
      chk($sformatf("div_busy_%0d", k), md_busy, (k < 10) ? 1 : 0);
      chk($sformatf("div_stall_%0d", k), stall, (k < 10) ? 1 : 0);
    end
    tick();

    // reset in the middle of a divide
    drive(mflo3, div12, 0, 0);
    tick();
    drive(mflo3, 0, 0, 0);
    tick();
    tick();
    chk("divrst_busy_t3", md_busy, 1);
    reset = 1'b1;
    tick();
    chk("divrst_busy_t4", md_busy, 0);
    chk("divrst_stall_t4", stall, 0);
    chk("divrst_cnt_t4", int'(dut.md_cnt), 0);
    reset = 1'b0;
    tick();
    chk("divrst_busy_t5", md_busy, 0);
`else
    // md ops behave as ordinary R-type without the busy tracker
    drive(mflo3, mult12, 0, 0);
    chk("nomd_busy", md_busy, 0);
    chk("nomd_stall", stall, 0);
    tick();
    drive(mflo3, div12, 0, 0);
    chk("nomd_div_busy", md_busy, 0);
`endif

    drive(0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
